// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber constants and butterfly mode encoding
package kyber_pkg;
  localparam int KYBER_Q = 3329;
  localparam int KYBER_DW = 12;
  typedef enum logic [1:0] {
    BF_MODE_CT     = 2'd0,
    BF_MODE_GS     = 2'd1,
    BF_MODE_ADDSUB = 2'd2,
    BF_MODE_SCALE  = 2'd3
  } bf_mode_t;
endpackage

// File: rtl/mod_mul_q.sv
// mod_mul_q: pipelined modular multiplier, p = x*y mod Q after MUL_LAT enabled edges
module mod_mul_q #(
  parameter int DW = 12,
  parameter int Q = 3329,
  parameter int MUL_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  output logic [DW-1:0] p
);
  localparam logic [2*DW-1:0] QW = (2*DW)'(Q);
  logic [2*DW-1:0] prod;
  // full-width product; reduction happens in the last register stage
  always_comb prod = (2*DW)'(x) * (2*DW)'(y);
  generate
    if (MUL_LAT == 1) begin : g_one
      // single stage: multiply and reduce into the only register
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) p <= '0;
        else if (en) p <= DW'(prod % QW);
    end else begin : g_pipe
      logic [2*DW-1:0] pr [MUL_LAT-1];
      // raw product pipeline followed by a reducing output stage
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          for (int k = 0; k < MUL_LAT-1; k++) pr[k] <= '0;
          p <= '0;
        end else if (en) begin
          pr[0] <= prod;
          for (int k = 1; k < MUL_LAT-1; k++) pr[k] <= pr[k-1];
          p <= DW'(pr[MUL_LAT-2] % QW);
        end
    end
  endgenerate
endmodule

// File: rtl/bf_array_pipe.sv
// bf_array_pipe: N_BU-lane pipelined mod-Q butterfly array with per-beat mode and stall handshake
module bf_array_pipe import kyber_pkg::*; #(
  parameter int N_BU = 4,
  parameter int DW = KYBER_DW,
  parameter int Q = KYBER_Q,
  parameter int MUL_LAT = 2,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [N_BU*DW-1:0]   in_a,
  input  logic [N_BU*DW-1:0]   in_b,
  input  logic [N_BU*DW-1:0]   in_w,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N_BU*DW-1:0]   out_x,
  output logic [N_BU*DW-1:0]   out_y,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);
  localparam logic [DW:0] QE = (DW+1)'(Q);

  function automatic logic [DW-1:0] madd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= QE) ? DW'(s - QE) : DW'(s);
  endfunction

  function automatic logic [DW-1:0] msub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] d;
    d = {1'b0, a} + QE - {1'b0, b};
    return (d >= QE) ? DW'(d - QE) : DW'(d);
  endfunction

  logic                en;
  bf_mode_t            mode_in;
  logic [MUL_LAT-1:0]  vq;
  bf_mode_t            mq [MUL_LAT];
  logic [TAG_W-1:0]    tq [MUL_LAT];

  // global stall: the whole pipe advances only when the output slot can move
  always_comb begin
    mode_in = bf_mode_t'(in_mode);
    en = !out_valid || out_ready;
    in_ready = en;
    busy = |vq || out_valid;
  end

  // valid/mode/tag sideband, one entry per multiplier stage plus the output register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vq <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        mq[k] <= BF_MODE_CT;
        tq[k] <= '0;
      end
      out_valid <= 1'b0;
      out_tag <= '0;
    end else if (en) begin
      vq[0] <= in_valid;
      mq[0] <= mode_in;
      tq[0] <= in_tag;
      for (int k = 1; k < MUL_LAT; k++) begin
        vq[k] <= vq[k-1];
        mq[k] <= mq[k-1];
        tq[k] <= tq[k-1];
      end
      out_valid <= vq[MUL_LAT-1];
      out_tag <= tq[MUL_LAT-1];
    end

  for (genvar i = 0; i < N_BU; i++) begin : g_lane
    logic [DW-1:0] a, b, w, mx, my, c0, p, ox, oy;
    logic          sumd, ct;
    logic [DW-1:0] cq [MUL_LAT];

    // pre stage: GS/ADDSUB multiply the difference and carry the sum, CT/SCALE multiply b and carry a
    always_comb begin
      a = in_a[i*DW +: DW];
      b = in_b[i*DW +: DW];
      w = in_w[i*DW +: DW];
      sumd = (mode_in == BF_MODE_GS) || (mode_in == BF_MODE_ADDSUB);
      mx = sumd ? msub(a, b) : b;
      my = (mode_in == BF_MODE_ADDSUB) ? DW'(1) : w;
      c0 = sumd ? madd(a, b) : a;
      ct = mq[MUL_LAT-1] == BF_MODE_CT;
    end

    mod_mul_q #(.DW(DW), .Q(Q), .MUL_LAT(MUL_LAT)) u_mul (
      .clk(clk), .rst_n(rst_n), .en(en), .x(mx), .y(my), .p(p)
    );

    // carried operand delay line aligned to the product, then the post add/sub output register
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        for (int k = 0; k < MUL_LAT; k++) cq[k] <= '0;
        ox <= '0;
        oy <= '0;
      end else if (en) begin
        cq[0] <= c0;
        for (int k = 1; k < MUL_LAT; k++) cq[k] <= cq[k-1];
        ox <= ct ? madd(cq[MUL_LAT-1], p) : cq[MUL_LAT-1];
        oy <= ct ? msub(cq[MUL_LAT-1], p) : p;
      end

    assign out_x[i*DW +: DW] = ox;
    assign out_y[i*DW +: DW] = oy;
  end
endmodule

// File: tb/tb_bf_array_pipe.sv
// tb_bf_array_pipe: directed self-checking bench for the butterfly array
module tb_bf_array_pipe;
  localparam int N = 4, DW = 12, Q = 3329, ML = 2, TW = 4, LAT = ML + 1, W = N * DW;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] in_mode = '0;
  logic [TW-1:0] in_tag = '0;
  logic [W-1:0] in_a = '0, in_b = '0, in_w = '0;
  logic in_ready, out_valid, busy;
  logic [W-1:0] out_x, out_y;
  logic [TW-1:0] out_tag;

  bf_array_pipe #(.N_BU(N), .DW(DW), .Q(Q), .MUL_LAT(ML), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_tag(in_tag), .in_a(in_a), .in_b(in_b), .in_w(in_w), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [W-1:0] x; logic [W-1:0] y; logic [TW-1:0] tag; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, stepno = 0, n_out = 0, last_out = -10;
  logic acc = 1'b0, hold_p = 1'b0;
  logic [W-1:0] hx, hy;
  logic [TW-1:0] ht;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] md, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] w, input logic [TW-1:0] tg);
    exp_t e;
    int ai, bi, wi, t, x, y;
    e.tag = tg;
    e.x = '0;
    e.y = '0;
    for (int l = 0; l < N; l++) begin
      ai = int'(a[l*DW +: DW]);
      bi = int'(b[l*DW +: DW]);
      wi = int'(w[l*DW +: DW]);
      t = (bi * wi) % Q;
      case (md)
        2'd0: begin x = (ai + t) % Q; y = (ai - t + Q) % Q; end
        2'd1: begin x = (ai + bi) % Q; y = (((ai - bi + Q) % Q) * wi) % Q; end
        2'd2: begin x = (ai + bi) % Q; y = (ai - bi + Q) % Q; end
        default: begin x = ai; y = t; end
      endcase
      e.x[l*DW +: DW] = DW'(x);
      e.y[l*DW +: DW] = DW'(y);
    end
    return e;
  endfunction

  function automatic logic [W-1:0] mk(input int base, input int inc);
    logic [W-1:0] r;
    for (int l = 0; l < N; l++) r[l*DW +: DW] = DW'((base + inc * l) % Q);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int l = 0; l < N; l++) r[l*DW +: DW] = DW'($urandom_range(0, Q - 1));
    return r;
  endfunction

  task automatic step(input logic v, input logic [1:0] md, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] w, input logic [TW-1:0] tg, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_mode = md; in_a = a; in_b = b; in_w = w; in_tag = tg; out_ready = ordy;
    #1;
    if (hold_p) begin
      chk("hold_valid", W'(out_valid), W'(1));
      chk("hold_x", out_x, hx);
      chk("hold_y", out_y, hy);
      chk("hold_tag", W'(out_tag), W'(ht));
    end
    if (out_valid && !out_ready) chk("in_ready_stall", W'(in_ready), '0);
    hold_p = out_valid && !out_ready;
    hx = out_x; hy = out_y; ht = out_tag;
    if (out_valid && out_ready) begin
      n_out++;
      last_out = stepno;
      if (q.size() == 0) chk("unexpected_out", W'(out_valid), '0);
      else begin
        e = q.pop_front();
        chk("sb_x", out_x, e.x);
        chk("sb_y", out_y, e.y);
        chk("sb_tag", W'(out_tag), W'(e.tag));
      end
    end
    acc = in_valid && in_ready;
    if (acc) q.push_back(model(md, a, b, w, tg));
    stepno++;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 2'd0, '0, '0, '0, '0, ordy);
  endtask

  task automatic lat_test(input string name, input logic [1:0] md, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] w, input logic [TW-1:0] tg, input logic [W-1:0] ex, input logic [W-1:0] ey);
    step(1'b1, md, a, b, w, tg, 1'b1);
    chk({name, "_acc"}, W'(acc), W'(1));
    for (int j = 1; j < LAT; j++) begin
      idle(1'b1);
      chk({name, "_early"}, W'(out_valid), '0);
    end
    idle(1'b1);
    chk({name, "_valid"}, W'(out_valid), W'(1));
    chk({name, "_x"}, out_x, ex);
    chk({name, "_y"}, out_y, ey);
    chk({name, "_tag"}, W'(out_tag), W'(tg));
  endtask

  initial begin
    int idx, n0, first, nacc;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", W'(out_valid), '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_x", out_x, '0);
    chk("rst_y", out_y, '0);
    chk("rst_tag", W'(out_tag), '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;

    lat_test("ct", 2'd0, {4{12'd100}}, {4{12'd200}}, {4{12'd17}}, 4'hA, {4{12'd171}}, {4{12'd29}});
    lat_test("gs", 2'd1, {4{12'd100}}, {4{12'd200}}, {4{12'd17}}, 4'h5, {4{12'd300}}, {4{12'd1629}});
    lat_test("addsub", 2'd2, {4{12'd3000}}, {4{12'd1000}}, {4{12'd1234}}, 4'h3, {4{12'd671}}, {4{12'd2000}});
    lat_test("scale", 2'd3, {4{12'd5}}, {4{12'd3328}}, {4{12'd3328}}, 4'hF, {4{12'd5}}, {4{12'd1}});
    lat_test("ct_lanes", 2'd0, {12'd3328, 12'd0, 12'd1, 12'd10}, {12'd1, 12'd3328, 12'd3328, 12'd2},
             {12'd1, 12'd3328, 12'd1, 12'd3}, 4'h1, {12'd0, 12'd1, 12'd0, 12'd16}, {12'd3327, 12'd3328, 12'd2, 12'd4});

    for (int j = 0; j < 24; j++) step(1'b1, 2'($urandom_range(0, 3)), rnd(), rnd(), rnd(), TW'(j), 1'b1);
    repeat (LAT + 2) idle(1'b1);
    chk("mix_drain", W'(q.size()), '0);

    n0 = n_out;
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      if (idx < 8) step(1'b1, 2'(idx % 4), mk(100 * idx + 7, 211), mk(3328 - 37 * idx, 97),
                        mk(idx * 113 + 5, 500), TW'(idx), !(c >= 3 && c <= 7));
      else idle(!(c >= 3 && c <= 7));
      if (acc) idx++;
    end
    chk("bp_sent", W'(idx), W'(8));
    chk("bp_count", W'(n_out - n0), W'(8));
    chk("bp_drain", W'(q.size()), '0);

    n0 = n_out;
    nacc = 0;
    first = stepno;
    for (int j = 0; j < 64; j++) begin
      step(1'b1, 2'(j % 4), mk(j * 53, 11), mk(3000 - j * 29, 401), mk(j * 7 + 1, 900), TW'(j), 1'b1);
      if (acc) nacc++;
    end
    for (int j = 0; j < 8; j++) begin
      idle(1'b1);
      if (last_out == stepno - 2) chk("tp_busy_fall", W'(busy), '0);
    end
    chk("tp_acc", W'(nacc), W'(64));
    chk("tp_count", W'(n_out - n0), W'(64));
    chk("tp_span", W'(last_out - first), W'(63 + LAT));

    step(1'b1, 2'd0, {4{12'd100}}, {4{12'd200}}, {4{12'd17}}, 4'h1, 1'b1);
    step(1'b1, 2'd1, {4{12'd100}}, {4{12'd200}}, {4{12'd17}}, 4'h2, 1'b1);
    step(1'b1, 2'd2, {4{12'd100}}, {4{12'd200}}, {4{12'd17}}, 4'h3, 1'b1);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", W'(out_valid), W'(1));
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_valid", W'(out_valid), '0);
    chk("mid_rst_busy", W'(busy), '0);
    chk("mid_rst_x", out_x, '0);
    chk("mid_rst_y", out_y, '0);
    chk("mid_rst_tag", W'(out_tag), '0);
    q.delete();
    hold_p = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < LAT + 2; j++) begin
      idle(1'b1);
      chk("stale_valid", W'(out_valid), '0);
    end
    lat_test("post_rst", 2'd0, {4{12'd100}}, {4{12'd200}}, {4{12'd17}}, 4'h9, {4{12'd171}}, {4{12'd29}});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
